alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Initiator side of the ALU operand interface. Accepts one 6502-level arithmetic/logic request per handshake, translates it into a single ALU issue (a, b, func, carry_in), and captures the ALU hold register and carry when wout is asserted. From the captured result it builds the N/Z/C/V flags and returns result plus flags to the execute control.
- LSR/ROR are executed locally, because the ALU has no right-shift path.

Parameters:
DATA_W, 8, operand/result width (equals REG_WIDTH)
WAIT_MAX, 4, phi2 cycles allowed in WAIT before timeout error

Ports:
phi2  in  1  clock; all state updates on posedge phi2 (ALU samples on phi1, between edges)
reset_n  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_op  in  4  0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 CMP, 6 ASL, 7 ROL, 8 LSR, 9 ROR, 10 INC, 11 DEC; 12-15 illegal
req_a  in  DATA_W  operand A
req_b  in  DATA_W  operand B (ignored for shifts, INC, DEC)
req_c  in  1  incoming carry flag
req_v  in  1  incoming overflow flag
req_dec  in  1  decimal mode flag
alu_a  out  DATA_W  to ALU a
alu_b  out  DATA_W  to ALU b
alu_func  out  5  to ALU func; SUM/AND/OR/XOR codes from the shared defines; 5'h1F when idle
alu_carry_in  out  1  to ALU carry_in
alu_add  in  DATA_W  from ALU hold register
alu_wout  in  1  ALU result valid
alu_carry_out  in  1  ALU carry
rsp_valid  out  1  response held until accepted
rsp_ready  in  1  response accepted
rsp_result  out  DATA_W  result (CMP: the difference, informational)
rsp_flags  out  4  {N, V, Z, C}
rsp_err  out  1  illegal op or timeout

Behaviour:
- Reset (phi2 edge with reset_n=0; reset_n has priority in every state):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_result=0; rsp_flags=0; rsp_err=0.
  - alu_func=5'h1F; alu_a=alu_b=0; alu_carry_in=0; timeout counter=0.
  - Reset in WAIT/DONE abandons the operation; no response is produced.
- States: IDLE, ISSUE, WAIT, ADJ (BCD only), DONE.
- IDLE:
  - On req_valid&req_ready, latch all req_* inputs.
  - Illegal op -> DONE with rsp_err=1, result 0, flags = {0, req_v, 0, req_c}.
  - LSR/ROR -> DONE directly (local shift): result={ROR?c:0, a[7:1]}, C=a[0].
  - All other legal ops -> ISSUE.
- ISSUE (exactly one cycle) drives:
  - ADC: a, b, SUM, c.
  - SBC: a, ~b, SUM, c.
  - CMP: a, ~b, SUM, 1.
  - AND/ORA/EOR: a, b, AND/OR/XOR.
  - ASL: a, a, SUM, 0.
  - ROL: a, a, SUM, c.
  - INC: a, 0, SUM, 1.
  - DEC: a, 8'hFF, SUM, 0.
  - Then -> WAIT.
- WAIT:
  - alu_func returns to 5'h1F; other ALU outputs hold.
  - On a phi2 edge with alu_wout=1: capture alu_add and alu_carry_out -> DONE (or ADJ).
  - Otherwise increment the counter. On reaching WAIT_MAX: -> DONE, err=1, result 0, flags pass-through.
- Flags:
  - N = result[7]; Z = (result==0).
  - C = alu_carry_out for ADC/SBC/CMP/ASL/ROL; C = req_c for logic ops, INC, DEC.
  - V = (a[7]==b_eff[7]) & (res[7]!=a[7]) for ADC/SBC, where b_eff is the driven alu_b. All other ops pass req_v through.
- DONE:
  - rsp_valid=1, outputs stable until rsp_ready.
  - On rsp_ready -> IDLE, rsp_valid=0.
  - req_ready is 0 throughout DONE.
- Sequencing: back-to-back requests are not overlapped. Minimum latency is req accept -> rsp_valid in 3 phi2 edges for ALU ops and 1 edge for LSR/ROR/illegal ops.

Optional Feature:
BCD_ADJUST_EN
- Defined:
  - ADC/SBC with req_dec=1 go WAIT -> ADJ for one cycle.
  - ADC adjust: add 6 to the low nibble if it is >9 or the binary half-carry is set; add 6 to the high nibble if it is >9 or the binary carry is set. C = decimal carry.
  - SBC adjust: subtract 6 per nibble on borrow.
  - N/Z are taken from the adjusted result; V from the binary result.
- Undefined: req_dec is ignored; ADJ state does not exist; behaviour is pure binary.

Test Plan:
- ADC a=0x50 b=0x50 c=0 -> alu_func=SUM, alu_carry_in=0; rsp_result=0xA0, flags N=1 V=1 Z=0 C=0; rsp_valid 3 edges after accept.
- SBC a=0x00 b=0x01 c=1 -> alu_b=0xFE; result 0xFF, N=1 V=0 Z=0 C=0. CMP a=0x40 b=0x40 -> Z=1 C=1 N=0, V equals req_v.
- LSR a=0x01 -> result 0x00, Z=1 C=1, alu_func stays 5'h1F throughout; ROR a=0x02 c=1 -> 0x81, N=1 C=0.
- Hold alu_wout=0 after ADC issue -> rsp_err=1 after WAIT_MAX (4) WAIT cycles; req_op=13 -> rsp_err=1 with no ALU issue.
- Assert reset_n=0 during WAIT, and separately hold rsp_ready=0 for 5 cycles in DONE. Reset case -> IDLE, req_ready=1, rsp_valid=0, no response. Held case -> response stable and no new request accepted.
- With BCD_ADJUST_EN: ADC dec a=0x19 b=0x28 c=0 -> 0x47 C=0; a=0x99 b=0x01 -> 0x00, Z=1 C=1.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one 6502 arithmetic/logic op to the shared ALU and returns result + {N,V,Z,C}.
// Optional decimal adjust for ADC/SBC is compiled in when BCD_ADJUST_EN is defined.
module alu_op_sequencer #(
  parameter int DATA_W   = 8,
  parameter int WAIT_MAX = 4
) (
  input  logic              phi2,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_c,
  input  logic              req_v,
  input  logic              req_dec,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_func,
  output logic              alu_carry_in,
  input  logic [DATA_W-1:0] alu_add,
  input  logic              alu_wout,
  input  logic              alu_carry_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on the phi2 edge where valid && ready are both high;
  // the producer holds valid and its payload stable until that edge.

  localparam int MSB   = DATA_W - 1;
  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  // Function codes matching the ALU's decode.
  localparam logic [4:0] FUNC_SUM  = 5'h00;
  localparam logic [4:0] FUNC_AND  = 5'h01;
  localparam logic [4:0] FUNC_OR   = 5'h02;
  localparam logic [4:0] FUNC_XOR  = 5'h03;
  localparam logic [4:0] FUNC_IDLE = 5'h1F;

  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBC = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORA = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_ASL = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_LSR = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_DEC = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
`ifdef BCD_ADJUST_EN
    ST_ADJ   = 3'd3,
`endif
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic              c_q, c_d;
  logic              v_q, v_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [4:0]        alu_func_q, alu_func_d;
  logic              alu_cin_q, alu_cin_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic              rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0] iss_b;
  logic [4:0]        iss_func;
  logic              iss_cin;
  logic [DATA_W-1:0] shift_res;
  logic              is_arith;
  logic              cap_c;
  logic              cap_v;

`ifdef BCD_ADJUST_EN
  logic              dec_q, dec_d;
  logic [DATA_W-1:0] bin_res_q, bin_res_d;
  logic              bin_c_q, bin_c_d;
  logic              bcd_half;
  logic [DATA_W:0]   bcd_lo;
  logic [DATA_W-1:0] bcd_hi;
  logic              bcd_c;
  logic              bcd_v;
`else
  logic              unused_dec;
  assign unused_dec = req_dec;
`endif

  // Operand/function selection for the single ALU issue, taken straight from the request.
  always_comb begin
    iss_b    = req_b;
    iss_func = FUNC_SUM;
    iss_cin  = req_c;
    case (req_op)
      OP_ADC: ;
      OP_SBC: iss_b = ~req_b;
      OP_CMP: begin
        iss_b   = ~req_b;
        iss_cin = 1'b1;
      end
      OP_AND: begin
        iss_func = FUNC_AND;
        iss_cin  = 1'b0;
      end
      OP_ORA: begin
        iss_func = FUNC_OR;
        iss_cin  = 1'b0;
      end
      OP_EOR: begin
        iss_func = FUNC_XOR;
        iss_cin  = 1'b0;
      end
      OP_ASL: begin
        iss_b   = req_a;
        iss_cin = 1'b0;
      end
      OP_ROL: iss_b = req_a;
      OP_INC: begin
        iss_b   = '0;
        iss_cin = 1'b1;
      end
      OP_DEC: begin
        iss_b   = '1;
        iss_cin = 1'b0;
      end
      default: ;
    endcase
  end

  // The ALU has no right-shift path, so LSR/ROR are formed here.
  assign shift_res = {(req_op == OP_ROR) & req_c, req_a[DATA_W-1:1]};

  assign is_arith = (op_q == OP_ADC) || (op_q == OP_SBC);
  assign cap_c    = (is_arith || op_q == OP_CMP || op_q == OP_ASL || op_q == OP_ROL)
                    ? alu_carry_out : c_q;
  // alu_b_q already holds the inverted operand for SBC, so one overflow rule covers both.
  assign cap_v    = is_arith
                    ? ((alu_a_q[MSB] == alu_b_q[MSB]) && (alu_add[MSB] != alu_a_q[MSB]))
                    : v_q;

`ifdef BCD_ADJUST_EN
  always_comb begin
    bcd_half = alu_a_q[4] ^ alu_b_q[4] ^ bin_res_q[4];
    bcd_lo   = {1'b0, bin_res_q};
    bcd_c    = bin_c_q;
    if (op_q == OP_ADC) begin
      if ((bin_res_q[3:0] > 4'd9) || bcd_half) bcd_lo = bcd_lo + (DATA_W+1)'(6);
      bcd_c  = bin_c_q || bcd_lo[DATA_W] || (bcd_lo[7:4] > 4'd9);
      bcd_hi = bcd_c ? bcd_lo[DATA_W-1:0] + DATA_W'(8'h60) : bcd_lo[DATA_W-1:0];
    end else begin
      // A clear half-carry / carry after the binary subtract means that digit borrowed.
      if (!bcd_half) bcd_lo = bcd_lo - (DATA_W+1)'(6);
      bcd_hi = bin_c_q ? bcd_lo[DATA_W-1:0] : bcd_lo[DATA_W-1:0] - DATA_W'(8'h60);
    end
    bcd_v = (alu_a_q[MSB] == alu_b_q[MSB]) && (bin_res_q[MSB] != alu_a_q[MSB]);
  end
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    c_d          = c_q;
    v_d          = v_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_func_d   = alu_func_q;
    alu_cin_d    = alu_cin_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
`ifdef BCD_ADJUST_EN
    dec_d        = dec_q;
    bin_res_d    = bin_res_q;
    bin_c_d      = bin_c_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          c_d  = req_c;
          v_d  = req_v;
`ifdef BCD_ADJUST_EN
          dec_d = req_dec;
`endif
          if (req_op > OP_DEC) begin
            state_d      = ST_DONE;
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            rsp_flags_d  = {1'b0, req_v, 1'b0, req_c};
          end else if (req_op == OP_LSR || req_op == OP_ROR) begin
            state_d      = ST_DONE;
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b0;
            rsp_result_d = shift_res;
            rsp_flags_d  = {shift_res[MSB], req_v, ~|shift_res, req_a[0]};
          end else begin
            // ALU outputs are registered, so they are loaded here to be valid during ISSUE.
            state_d    = ST_ISSUE;
            alu_a_d    = req_a;
            alu_b_d    = iss_b;
            alu_func_d = iss_func;
            alu_cin_d  = iss_cin;
          end
        end
      end
      ST_ISSUE: begin
        state_d    = ST_WAIT;
        alu_func_d = FUNC_IDLE;
        cnt_d      = '0;
      end
      ST_WAIT: begin
        if (alu_wout) begin
          state_d      = ST_DONE;
          rsp_valid_d  = 1'b1;
          rsp_err_d    = 1'b0;
          rsp_result_d = alu_add;
          rsp_flags_d  = {alu_add[MSB], cap_v, ~|alu_add, cap_c};
`ifdef BCD_ADJUST_EN
          bin_res_d = alu_add;
          bin_c_d   = alu_carry_out;
          if (dec_q && is_arith) begin
            state_d     = ST_ADJ;
            rsp_valid_d = 1'b0;
          end
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d      = ST_DONE;
          rsp_valid_d  = 1'b1;
          rsp_err_d    = 1'b1;
          rsp_result_d = '0;
          rsp_flags_d  = {1'b0, v_q, 1'b0, c_q};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef BCD_ADJUST_EN
      ST_ADJ: begin
        state_d      = ST_DONE;
        rsp_valid_d  = 1'b1;
        rsp_err_d    = 1'b0;
        rsp_result_d = bcd_hi;
        rsp_flags_d  = {bcd_hi[MSB], bcd_v, ~|bcd_hi, bcd_c};
      end
`endif
      ST_DONE: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge phi2) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      c_q          <= 1'b0;
      v_q          <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_func_q   <= FUNC_IDLE;
      alu_cin_q    <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
`ifdef BCD_ADJUST_EN
      dec_q        <= 1'b0;
      bin_res_q    <= '0;
      bin_c_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      c_q          <= c_d;
      v_q          <= v_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_func_q   <= alu_func_d;
      alu_cin_q    <= alu_cin_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
`ifdef BCD_ADJUST_EN
      dec_q        <= dec_d;
      bin_res_q    <= bin_res_d;
      bin_c_q      <= bin_c_d;
`endif
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_func     = alu_func_q;
  assign alu_carry_in = alu_cin_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_flags    = rsp_flags_q;
  assign rsp_err      = rsp_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: drives 6502 ALU requests, models the ALU, and scoreboards issues and responses.
module tb_alu_op_sequencer;

  localparam int DATA_W   = 8;
  localparam int WAIT_MAX = 4;
`ifdef BCD_ADJUST_EN
  localparam bit BCD_ON = 1'b1;
`else
  localparam bit BCD_ON = 1'b0;
`endif

  localparam logic [4:0] F_SUM  = 5'h00;
  localparam logic [4:0] F_AND  = 5'h01;
  localparam logic [4:0] F_OR   = 5'h02;
  localparam logic [4:0] F_XOR  = 5'h03;
  localparam logic [4:0] F_IDLE = 5'h1F;

  logic              phi2 = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [3:0]        req_op = '0;
  logic [DATA_W-1:0] req_a = '0;
  logic [DATA_W-1:0] req_b = '0;
  logic              req_c = 1'b0;
  logic              req_v = 1'b0;
  logic              req_dec = 1'b0;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [4:0]        alu_func;
  logic              alu_carry_in;
  logic [DATA_W-1:0] alu_add = '0;
  logic              alu_wout = 1'b0;
  logic              alu_carry_out = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_result;
  logic [3:0]        rsp_flags;
  logic              rsp_err;
  logic [2:0]        dbg_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [12:0] exp_q[$];   // {err, N, V, Z, C, result}
  logic [21:0] iss_q[$];   // {func, a, b, carry_in}
  bit          alu_mute = 1'b0;

  alu_op_sequencer #(.DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)) dut (
    .phi2(phi2), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_v(req_v), .req_dec(req_dec),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_carry_in(alu_carry_in),
    .alu_add(alu_add), .alu_wout(alu_wout), .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 phi2 = ~phi2;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model of the architectural result.
  function automatic logic [12:0] ref_rsp(input logic [3:0] op, input logic [7:0] a, b,
                                         input logic c, v, dec);
    logic [8:0] s;
    logic [7:0] r;
    logic [4:0] lo, hi;
    logic       cc, vv, brw;
    cc = c;
    vv = v;
    r  = '0;
    if (op > 4'd11) return {1'b1, 1'b0, v, 1'b0, c, 8'h00};
    case (op)
      4'd0: begin
        s = a + b + c; r = s[7:0]; cc = s[8];
        vv = ~(a[7] ^ b[7]) & (a[7] ^ r[7]);
        if (BCD_ON && dec) begin
          lo = a[3:0] + b[3:0] + c;
          if (lo > 5'd9) lo = lo + 5'd6;
          hi = a[7:4] + b[7:4] + lo[4];
          if (hi > 5'd9) hi = hi + 5'd6;
          r = {hi[3:0], lo[3:0]}; cc = hi[4];
        end
      end
      4'd1: begin
        s = {1'b0, a} - {1'b0, b} - {8'b0, ~c}; r = s[7:0]; cc = ~s[8];
        vv = (a[7] ^ b[7]) & (a[7] ^ r[7]);
        if (BCD_ON && dec) begin
          lo = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, ~c};
          brw = lo[4];
          if (brw) lo = lo - 5'd6;
          hi = {1'b0, a[7:4]} - {1'b0, b[7:4]} - {4'b0, brw};
          if (hi[4]) hi = hi - 5'd6;
          r = {hi[3:0], lo[3:0]}; cc = ~hi[4];
        end
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; cc = ~s[8]; end
      4'd6: begin r = {a[6:0], 1'b0}; cc = a[7]; end
      4'd7: begin r = {a[6:0], c}; cc = a[7]; end
      4'd8: begin r = {1'b0, a[7:1]}; cc = a[0]; end
      4'd9: begin r = {c, a[7:1]}; cc = a[0]; end
      4'd10: r = a + 8'd1;
      default: r = a - 8'd1;
    endcase
    return {1'b0, r[7], vv, (r == 8'h00), cc, r};
  endfunction

  function automatic logic [21:0] exp_issue(input logic [3:0] op, input logic [7:0] a, b,
                                           input logic c);
    case (op)
      4'd0:  return {F_SUM, a, b, c};
      4'd1:  return {F_SUM, a, ~b, c};
      4'd2:  return {F_AND, a, b, 1'b0};
      4'd3:  return {F_OR, a, b, 1'b0};
      4'd4:  return {F_XOR, a, b, 1'b0};
      4'd5:  return {F_SUM, a, ~b, 1'b1};
      4'd6:  return {F_SUM, a, a, 1'b0};
      4'd7:  return {F_SUM, a, a, c};
      4'd10: return {F_SUM, a, 8'h00, 1'b1};
      default: return {F_SUM, a, 8'hFF, 1'b0};
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic dec);
    if (op > 4'd11 || op == 4'd8 || op == 4'd9) return 1;
    if (BCD_ON && dec && op < 4'd2) return 4;
    return 3;
  endfunction

  function automatic bit issues(input logic [3:0] op);
    return (op <= 4'd11) && (op != 4'd8) && (op != 4'd9);
  endfunction

  // ALU model: samples an issue during the phi1 half and presents the hold register in WAIT.
  always @(negedge phi2) begin : alu_model
    logic [8:0] s;
    if (reset_n && alu_func !== F_IDLE) begin
      check_eq("issue_pending", (iss_q.size() != 0), 1);
      if (iss_q.size() != 0) check_eq("issue", {alu_func, alu_a, alu_b, alu_carry_in}, iss_q.pop_front());
      case (alu_func)
        F_AND:   s = {1'b0, alu_a & alu_b};
        F_OR:    s = {1'b0, alu_a | alu_b};
        F_XOR:   s = {1'b0, alu_a ^ alu_b};
        default: s = alu_a + alu_b + alu_carry_in;
      endcase
      alu_add       = s[7:0];
      alu_carry_out = s[8];
      alu_wout      = !alu_mute;
    end
  end

  // Response scoreboard: compare on the cycle the response is accepted.
  always @(negedge phi2) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      check_eq("rsp_pending", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_eq("rsp", {rsp_err, rsp_flags, rsp_result}, exp_q.pop_front());
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, b, input logic c, v, dec,
                        input bit mute, input logic [12:0] exp_rsp, input int exp_lat);
    int lat;
    @(negedge phi2);
    alu_mute = mute;
    req_op = op; req_a = a; req_b = b; req_c = c; req_v = v; req_dec = dec;
    req_valid = 1'b1;
    if (issues(op)) iss_q.push_back(exp_issue(op, a, b, c));
    exp_q.push_back(exp_rsp);
    check_eq("req_ready_idle", req_ready, 1);
    @(posedge phi2); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge phi2); #1;
      lat++;
    end
    check_eq("rsp_latency", lat, exp_lat);
    while (rsp_valid && lat < 80) begin
      @(posedge phi2); #1;
      lat++;
    end
    alu_mute = 1'b0;
  endtask

  task automatic run_ref(input logic [3:0] op, input logic [7:0] a, b, input logic c, v, dec);
    run_op(op, a, b, c, v, dec, 1'b0, ref_rsp(op, a, b, c, v, dec), lat_of(op, dec));
  endtask

  initial begin
    logic [3:0]  op;
    logic [12:0] hold_exp;

    // Reset
    repeat (2) @(posedge phi2);
    #1;
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_all", {rsp_err, rsp_flags, rsp_result}, 0);
    check_eq("rst_alu_func", alu_func, F_IDLE);
    check_eq("rst_alu_ops", {alu_a, alu_b, alu_carry_in}, 0);
    reset_n = 1'b1;

    // Directed arithmetic / logic / local shifts
    run_ref(4'd0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0);
    check_eq("adc_5050_expect", ref_rsp(4'd0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0), 13'h0_A0 | 13'h0C00);
    run_ref(4'd1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    run_ref(4'd5, 8'h40, 8'h40, 1'b0, 1'b1, 1'b0);
    run_ref(4'd8, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    run_ref(4'd9, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0);
    run_ref(4'd6, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0);
    run_ref(4'd11, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);

    // Timeout: ALU never asserts wout; 1 accept + 1 issue + WAIT_MAX wait edges
    run_op(4'd0, 8'h12, 8'h34, 1'b1, 1'b1, 1'b0, 1'b1,
           {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00}, 2 + WAIT_MAX);

    // Illegal ops
    run_ref(4'd13, 8'h55, 8'hAA, 1'b1, 1'b0, 1'b0);
    run_ref(4'd15, 8'h55, 8'hAA, 1'b0, 1'b1, 1'b0);

    // Reset while waiting on the ALU abandons the operation
    @(negedge phi2);
    alu_mute = 1'b1;
    req_op = 4'd0; req_a = 8'h11; req_b = 8'h22; req_c = 1'b0; req_v = 1'b0; req_dec = 1'b0;
    req_valid = 1'b1;
    iss_q.push_back(exp_issue(4'd0, 8'h11, 8'h22, 1'b0));
    @(posedge phi2); #1;
    req_valid = 1'b0;
    @(posedge phi2); #1;
    reset_n = 1'b0;
    @(posedge phi2); #1;
    reset_n = 1'b1;
    check_eq("wrst_req_ready", req_ready, 1);
    check_eq("wrst_rsp_valid", rsp_valid, 0);
    check_eq("wrst_alu_func", alu_func, F_IDLE);
    check_eq("wrst_rsp_err", rsp_err, 0);
    repeat (8) @(posedge phi2);
    #1;
    check_eq("wrst_no_rsp", rsp_valid, 0);
    alu_mute = 1'b0;

    // Response held in DONE while a new request waits
    rsp_ready = 1'b0;
    hold_exp = ref_rsp(4'd8, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge phi2);
    req_op = 4'd8; req_a = 8'h80; req_b = 8'h00; req_c = 1'b0; req_v = 1'b1;
    req_valid = 1'b1;
    exp_q.push_back(hold_exp);
    @(posedge phi2); #1;
    req_op = 4'd0; req_a = 8'h01; req_b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge phi2);
      check_eq("hold_valid", rsp_valid, 1);
      check_eq("hold_rsp", {rsp_err, rsp_flags, rsp_result}, hold_exp);
      check_eq("hold_req_ready", req_ready, 0);
    end
    @(posedge phi2); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge phi2); #1;
    check_eq("hold_released", rsp_valid, 0);

    // Decimal-mode requests (binary result when the adjust is not built)
    run_ref(4'd0, 8'h19, 8'h28, 1'b0, 1'b0, 1'b1);
    run_ref(4'd0, 8'h99, 8'h01, 1'b0, 1'b0, 1'b1);
    run_ref(4'd1, 8'h50, 8'h01, 1'b1, 1'b0, 1'b1);

    // Random legal and illegal ops
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 12));
      run_ref(op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(posedge phi2);
    #1;
    check_eq("exp_q_drained", exp_q.size(), 0);
    check_eq("iss_q_drained", iss_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
